mix_i2s_tx: RTL and testbench

- Sink end of the per-channel effects chain.
- Captures the CHANNELS wet samples once per audio sample period and mixes them to one mono word. Each channel has its own gain and mute, and the sum saturates to WIDTH bits.
- The mixed word is serialized as standard I2S (same word on left and right) to the DAC.
- Runs on the 11.29 MHz audio clock: 256 clk_in cycles per 44.1 kHz frame.

---
 rtl/mix_i2s_tx.sv | 178 +++++++++++++++++
 tb/tb_mix_i2s_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_i2s_tx.sv
// mix_i2s_tx: per-channel gain/mute mixer with a saturating sum,
// sent as mono I2S (same word in both halves), 256 clk_in per frame.
module mix_i2s_tx #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [CHANNELS*WIDTH-1:0] data_wet,
    input  logic [CHANNELS*8-1:0]     gain,
    input  logic [CHANNELS-1:0]       mute,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      i2s_bclk,
    output logic                      i2s_lrclk,
    output logic                      i2s_sdata,
    output logic                      clip_out,
    output logic                      overrun_out,
    output logic                      underrun_out
);

    localparam int CW = $clog2(CHANNELS);
    localparam int AW = WIDTH + 9 + CW;
    localparam int KW = (CHANNELS > 1) ? CW : 1;
    localparam int PW = WIDTH + 9;

    localparam logic [KW-1:0] K_LAST = KW'(CHANNELS - 1);

    localparam logic signed [AW-1:0] SMAX =
        {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN =
        {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [KW-1:0]           k_q;
    logic signed [AW-1:0]    acc_q;
    logic signed [WIDTH-1:0] smp_q [CHANNELS];
    logic [7:0]              gain_q [CHANNELS];
    logic [CHANNELS-1:0]     mute_q;

    logic [WIDTH-1:0]        pend_q;
    logic                    pend_vld_q;
    logic [WIDTH-1:0]        out_word_q;
    logic [7:0]              cnt_q;

    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    sh;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [WIDTH-1:0]        sat_word;
    logic [4:0]              slot;
    logic                    sdata_d;
    logic                    frame_load;

    assign frame_load   = (cnt_q == 8'hFF);
    assign sample_ready = (state_q == IDLE);

    // Event pulses are reported in the cycle the event happens.
    assign clip_out = !rst_in && (state_q == SAT) && (sat_hi || sat_lo);
    assign overrun_out = !rst_in &&
        ((sample_valid && state_q != IDLE) ||
         (state_q == SAT && pend_vld_q && !frame_load));
    assign underrun_out = !rst_in && frame_load && !pend_vld_q;

    // Next-state logic for the capture/accumulate/saturate sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_valid) state_d = MAC;
            MAC:     if (k_q == K_LAST) state_d = SAT;
            SAT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Weighted contribution of the channel selected by k.
    always_comb begin
        prod = '0;
        if (!mute_q[k_q])
            prod = PW'(smp_q[k_q]) * PW'($signed({1'b0, gain_q[k_q]}));
    end

    // Drop the Q1.7 fraction and clamp to the output word range.
    always_comb begin
        sh       = acc_q >>> 7;
        sat_hi   = (sh > SMAX);
        sat_lo   = (sh < SMIN);
        sat_word = sh[WIDTH-1:0];
        if (sat_hi)
            sat_word = SMAX[WIDTH-1:0];
        else if (sat_lo)
            sat_word = SMIN[WIDTH-1:0];
    end

    // Pick the serial bit for the current slot; slot 0 is padding.
    always_comb begin
        slot    = cnt_q[6:2];
        sdata_d = 1'b0;
        for (int i = 1; i <= WIDTH; i++)
            if (slot == 5'(i))
                sdata_d = out_word_q[WIDTH-i];
    end

    // Mixer state register.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Sample capture and multiply-accumulate datapath.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            k_q    <= '0;
            acc_q  <= '0;
            mute_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                smp_q[c]  <= '0;
                gain_q[c] <= '0;
            end
        end else if (state_q == IDLE && sample_valid) begin
            k_q    <= '0;
            acc_q  <= '0;
            mute_q <= mute;
            for (int c = 0; c < CHANNELS; c++) begin
                smp_q[c]  <= data_wet[c*WIDTH +: WIDTH];
                gain_q[c] <= gain[c*8 +: 8];
            end
        end else if (state_q == MAC) begin
            acc_q <= acc_q + AW'(prod);
            k_q   <= k_q + KW'(1);
        end
    end

    // Pending slot and frame word; a frame load sees the old pending.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            out_word_q <= '0;
        end else begin
            if (frame_load) begin
                if (pend_vld_q)
                    out_word_q <= pend_q;
                pend_vld_q <= 1'b0;
            end
            if (state_q == SAT) begin
                pend_q     <= sat_word;
                pend_vld_q <= 1'b1;
            end
        end
    end

    // Frame counter and registered I2S pins.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
        end else begin
            cnt_q     <= cnt_q + 8'd1;
            i2s_bclk  <= cnt_q[1];
            i2s_lrclk <= cnt_q[7];
            i2s_sdata <= sdata_d;
        end
    end

endmodule

// File: tb/tb_mix_i2s_tx.sv
// tb_mix_i2s_tx: table vectors, hand sequences and random mixes,
// decoded from the I2S pins and compared with an arithmetic model.
module tb_mix_i2s_tx;

    localparam int W  = 16;
    localparam int CH = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [CH*W-1:0]   data_wet;
    logic [CH*8-1:0]   gain;
    logic [CH-1:0]     mute;
    logic              sample_valid;
    logic              sample_ready;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_sdata;
    logic              clip_out;
    logic              overrun_out;
    logic              underrun_out;

    mix_i2s_tx #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .data_wet     (data_wet),
        .gain         (gain),
        .mute         (mute),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .clip_out     (clip_out),
        .overrun_out  (overrun_out),
        .underrun_out (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int fc = 0;

    // Cycle number and expected frame position (cnt restarts on reset).
    always @(posedge clk_in) begin
        cyc++;
        fc = rst_in ? 0 : (fc + 1) % 256;
    end

    int clip_q[$];
    int ov_q[$];
    int und_fc_q[$];
    int und_cyc_q[$];

    // Event pulse recorder.
    always @(negedge clk_in) begin
        if (clip_out) clip_q.push_back(cyc);
        if (overrun_out) ov_q.push_back(cyc);
        if (underrun_out) begin
            und_fc_q.push_back(fc);
            und_cyc_q.push_back(cyc);
        end
    end

    typedef struct {
        bit             lr;
        logic [W-1:0]   w;
        bit             pad;
        int             start;
    } half_t;

    half_t halves[$];
    bit           have, pb, plr, cur_lr, hpad;
    logic [W-1:0] hw;
    int           hstart, slot_n;
    int           last_rise = -1;
    int           last_lr = -1;
    int           bclk_bad = 0;
    int           lr_bad = 0;

    // I2S receiver: words shifted in on bclk rising edges.
    always @(negedge clk_in) begin
        if (rst_in) begin
            have = 0; pb = 0; plr = 0; cur_lr = 0;
            last_rise = -1; last_lr = -1;
        end else begin
            if (i2s_lrclk != plr) begin
                if (last_lr >= 0 && cyc - last_lr != 128) lr_bad++;
                last_lr = cyc;
            end
            if (i2s_bclk && !pb) begin
                if (last_rise >= 0 && cyc - last_rise != 4) bclk_bad++;
                last_rise = cyc;
                if (i2s_lrclk != cur_lr) begin
                    if (have) halves.push_back('{cur_lr, hw, hpad, hstart});
                    have = 1; cur_lr = i2s_lrclk; hstart = cyc;
                    slot_n = 0; hw = '0; hpad = !i2s_sdata;
                end else begin
                    slot_n++;
                    if (slot_n >= 1 && slot_n <= W)
                        hw = {hw[W-2:0], i2s_sdata};
                    else if (i2s_sdata)
                        hpad = 0;
                end
            end
            pb = i2s_bclk;
            plr = i2s_lrclk;
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_cnt(input int c);
        bit hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            step();
            if (fc == c) hit = 1;
        end
        check("cnt_wait", hit, 1);
    endtask

    task automatic strobe(input logic [CH*W-1:0] d, input logic [CH*8-1:0] g,
                          input logic [CH-1:0] m, output int t);
        data_wet = d; gain = g; mute = m;
        sample_valid = 1; t = cyc;
        step();
        sample_valid = 0;
    endtask

    task automatic get_frame(input int t0, output logic [W-1:0] l,
                             output logic [W-1:0] r, output bit pad);
        bit found = 0;
        l = '0; r = '0; pad = 0;
        for (int n = 0; n < 800 && !found; n++) begin
            step();
            for (int i = 0; i + 1 < halves.size(); i++)
                if (!found && halves[i].lr == 0 && halves[i].start > t0 &&
                    halves[i+1].lr == 1) begin
                    l = halves[i].w; r = halves[i+1].w;
                    pad = halves[i].pad && halves[i+1].pad;
                    found = 1;
                end
        end
        check("frame_seen", found, 1);
    endtask

    function automatic logic [CH*W-1:0] pk(int a, int b, int c, int d);
        pk = {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [CH*8-1:0] gpk(int a, int b, int c, int d);
        gpk = {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Reference: integer weighted sum, floor divide by 128, clamp.
    function automatic void mix_model(input logic [CH*W-1:0] d,
                                      input logic [CH*8-1:0] g,
                                      input logic [CH-1:0] m,
                                      output logic [W-1:0] r,
                                      output bit clip);
        longint sum, q, lo, hi, rem;
        sum = 0;
        for (int k = 0; k < CH; k++)
            if (!m[k])
                sum += longint'($signed(d[k*W +: W])) * longint'(g[k*8 +: 8]);
        rem = ((sum % 128) + 128) % 128;
        q = (sum - rem) / 128;
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -hi - 1;
        clip = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        r = W'(q);
    endfunction

    typedef struct {
        logic [CH*W-1:0] d;
        logic [CH*8-1:0] g;
        logic [CH-1:0]   m;
        logic [W-1:0]    exp;
        bit              clip;
    } vec_t;

    vec_t tbl[9];

    function automatic int clip_code(input int t, input int off);
        if (clip_q.size() == 0) return 0;
        if (clip_q.size() == 1 && clip_q[0] == t + off) return 1;
        return 2;
    endfunction

    initial begin
        logic [W-1:0]    l, r, e;
        logic [CH*W-1:0] d;
        logic [CH*8-1:0] g;
        logic [CH-1:0]   m;
        bit              pad, ec;
        int              t, ta, tb, rc;
        logic [CH*8-1:0] g128;

        g128 = gpk(128, 128, 128, 128);
        tbl[0] = '{pk(1000, 2000, -500, 0), g128, 4'b0000, 16'h09C4, 0};
        tbl[1] = '{pk(30000, 30000, 30000, 30000), g128, 4'b0000, 16'h7FFF, 1};
        tbl[2] = '{pk(-32768, -32768, -32768, -32768), g128, 4'b0000, 16'h8000, 1};
        tbl[3] = '{pk(1000, 20000, 100, 0), gpk(64, 128, 255, 128), 4'b0010,
                   16'h02BB, 0};
        tbl[4] = '{pk(-1, 0, 0, 0), gpk(1, 128, 128, 128), 4'b0000, 16'hFFFF, 0};
        tbl[5] = '{pk(32767, 0, 0, 0), g128, 4'b0000, 16'h7FFF, 0};
        tbl[6] = '{pk(16384, 0, 0, 0), gpk(255, 0, 0, 0), 4'b0000, 16'h7F80, 0};
        tbl[7] = '{pk(30000, 30000, 30000, 30000), g128, 4'b1111, 16'h0000, 0};
        tbl[8] = '{pk(32767, 1, 0, 0), g128, 4'b0000, 16'h7FFF, 1};

        rst_in = 1; sample_valid = 0;
        data_wet = '0; gain = '0; mute = '0;

        repeat (3) begin
            @(negedge clk_in);
            check("reset_out", {i2s_bclk, i2s_lrclk, i2s_sdata, clip_out,
                                overrun_out, underrun_out, sample_ready},
                  7'b0000001);
        end
        step();
        rst_in = 0;

        // Idle: one underrun per frame at cnt 255, silent words.
        wait_cnt(8);
        und_fc_q.delete();
        wait_cnt(8);
        check("underrun_idle",
              und_fc_q.size() == 1 ? und_fc_q[0] : 1000 + und_fc_q.size(), 255);
        get_frame(cyc, l, r, pad);
        check("idle_left", l, 0);
        check("idle_right", r, 0);
        check("idle_pad", pad, 1);

        // Table vectors, strobed mid-frame.
        for (int i = 0; i < 9; i++) begin
            wait_cnt(64);
            clip_q.delete();
            ov_q.delete();
            strobe(tbl[i].d, tbl[i].g, tbl[i].m, t);
            get_frame(t, l, r, pad);
            check($sformatf("vec%0d_left", i), l, tbl[i].exp);
            check($sformatf("vec%0d_right", i), r, tbl[i].exp);
            check($sformatf("vec%0d_pad", i), pad, 1);
            check($sformatf("vec%0d_clip", i), clip_code(t, CH + 1), tbl[i].clip);
            check($sformatf("vec%0d_no_ov", i), ov_q.size(), 0);
        end

        // Second strobe while busy is dropped.
        wait_cnt(64);
        ov_q.delete();
        strobe(tbl[0].d, tbl[0].g, tbl[0].m, t);
        for (int i = 1; i <= CH + 2; i++) begin
            if (i == 2) begin
                data_wet = tbl[1].d; gain = tbl[1].g; mute = tbl[1].m;
                sample_valid = 1;
            end else begin
                sample_valid = 0;
            end
            @(negedge clk_in);
            check($sformatf("ready_t%0d", i), sample_ready,
                  (i >= 1 && i <= CH + 1) ? 0 : 1);
            step();
        end
        sample_valid = 0;
        get_frame(t, l, r, pad);
        check("drop_left", l, 16'h09C4);
        check("drop_right", r, 16'h09C4);
        check("drop_ov", ov_q.size() == 1 && ov_q[0] == t + 2, 1);

        // Two mixes in one frame: the later one wins.
        wait_cnt(20);
        ov_q.delete();
        strobe(tbl[1].d, tbl[1].g, tbl[1].m, ta);
        wait_cnt(100);
        strobe(tbl[3].d, tbl[3].g, tbl[3].m, tb);
        get_frame(tb, l, r, pad);
        check("double_left", l, 16'h02BB);
        check("double_right", r, 16'h02BB);
        check("double_ov", ov_q.size() == 1 && ov_q[0] == tb + CH + 1, 1);

        // No strobe for a frame: underrun, previous word repeats.
        wait_cnt(8);
        und_fc_q.delete();
        wait_cnt(8);
        check("underrun_gap",
              und_fc_q.size() == 1 ? und_fc_q[0] : 1000 + und_fc_q.size(), 255);
        get_frame(cyc, l, r, pad);
        check("repeat_left", l, 16'h02BB);
        check("repeat_right", r, 16'h02BB);

        // Reset during MAC discards the mix and restarts the counter.
        wait_cnt(64);
        clip_q.delete();
        strobe(tbl[1].d, tbl[1].g, tbl[1].m, t);
        step();
        rst_in = 1;
        step();
        @(negedge clk_in);
        check("reset_mid_out", {i2s_bclk, i2s_lrclk, i2s_sdata, clip_out,
                                overrun_out, underrun_out, sample_ready},
              7'b0000001);
        step();
        rst_in = 0;
        rc = cyc;
        und_cyc_q.delete();
        get_frame(rc, l, r, pad);
        check("rst_first_underrun",
              und_cyc_q.size() >= 1 ? und_cyc_q[0] - rc : -1, 255);
        check("rst_left", l, 0);
        check("rst_right", r, 0);
        check("rst_no_clip", clip_q.size(), 0);

        // Random mixes against the arithmetic model.
        for (int it = 0; it < 10; it++) begin
            d = {$urandom(), $urandom()};
            g = $urandom();
            if (it % 2 == 1) g = g & 32'h3F3F3F3F;
            m = 4'($urandom());
            if (it % 3 == 0) m = 4'b0000;
            mix_model(d, g, m, e, ec);
            wait_cnt($urandom_range(0, 200));
            clip_q.delete();
            strobe(d, g, m, t);
            get_frame(t, l, r, pad);
            check($sformatf("rnd%0d_left", it), l, e);
            check($sformatf("rnd%0d_right", it), r, e);
            check($sformatf("rnd%0d_clip", it), clip_code(t, CH + 1), ec);
        end

        check("bclk_period", bclk_bad, 0);
        check("lrclk_period", lr_bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
